// File: rtl/nios2_debug_slave_cmd_queue.sv
// System-clock-side command receiver for the Nios II JTAG debug slave.
// Synchronises the update-DR toggle, queues {ir, sr} snapshots and issues per-instruction strobes on accept.
module nios2_debug_slave_cmd_queue #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACTION_BIT  = DATA_W - 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 udr_toggle,
    input  logic [IR_W-1:0]      ir_in,
    input  logic [DATA_W-1:0]    sr,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [IR_W-1:0]      cmd_ir,
    output logic [DATA_W-1:0]    cmd_data,
    output logic [DATA_W-1:0]    jdo,
    output logic [(1<<IR_W)-1:0] take_action,
    output logic [(1<<IR_W)-1:0] take_no_action,
    output logic                 ack_toggle,
    output logic                 overflow,
    output logic [7:0]           drop_cnt,
    input  logic                 clear_overflow
);

    localparam int AW      = $clog2(DEPTH);
    localparam int PTR_W   = AW + 1;
    localparam int NCH     = 1 << IR_W;
    localparam int ENT_W   = IR_W + DATA_W;
    localparam int ARM_MAX = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(ARM_MAX + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [ARM_W-1:0]       r_arm_cnt;
    logic                   w_sync_out;
    logic                   w_armed;
    logic                   w_capture;

    logic [ENT_W-1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic [ENT_W-1:0]       w_head;
    logic [NCH-1:0]         w_onehot;

    logic [DATA_W-1:0]      r_jdo;
    logic [NCH-1:0]         r_take_action;
    logic [NCH-1:0]         r_take_no_action;
    logic                   r_ack_toggle;
    logic                   r_overflow;
    logic [7:0]             r_drop_cnt;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_armed    = (r_arm_cnt == ARM_W'(ARM_MAX));
    // A level already present at reset release looks like an edge; the arm window swallows it.
    assign w_capture  = w_armed & (w_sync_out ^ r_prev);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync    <= '0;
            r_prev    <= 1'b0;
            r_arm_cnt <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], udr_toggle};
            r_prev <= w_sync_out;
            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt + ARM_W'(1);
            end
        end
    end

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_pop   = cmd_valid & cmd_ready;
    assign w_push  = w_capture & (~w_full | w_pop);
    assign w_drop  = w_capture & w_full & ~w_pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // NOTE: storage has no reset; the head is masked while empty, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {ir_in, sr};
        end
    end

    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign cmd_valid = ~w_empty;
    assign cmd_ir    = cmd_valid ? w_head[ENT_W-1 -: IR_W] : '0;
    assign cmd_data  = cmd_valid ? w_head[DATA_W-1:0]      : '0;

    // NOTE: default assigned first so the indexed write cannot infer a latch.
    always_comb begin
        w_onehot         = '0;
        w_onehot[cmd_ir] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_jdo            <= '0;
            r_take_action    <= '0;
            r_take_no_action <= '0;
            r_ack_toggle     <= 1'b0;
        end else if (w_pop) begin
            r_jdo            <= cmd_data;
            r_ack_toggle     <= ~r_ack_toggle;
            r_take_action    <= cmd_data[ACTION_BIT] ? w_onehot : '0;
            r_take_no_action <= cmd_data[ACTION_BIT] ? '0 : w_onehot;
        end else begin
            r_take_action    <= '0;
            r_take_no_action <= '0;
        end
    end

    // A drop in the same cycle as a clear is still recorded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clear_overflow) begin
            r_overflow <= w_drop;
            r_drop_cnt <= {7'd0, w_drop};
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign jdo            = r_jdo;
    assign take_action    = r_take_action;
    assign take_no_action = r_take_no_action;
    assign ack_toggle     = r_ack_toggle;
    assign overflow       = r_overflow;
    assign drop_cnt       = r_drop_cnt;

endmodule

// File: tb/tb_nios2_debug_slave_cmd_queue.sv
// Randomised and directed bench for nios2_debug_slave_cmd_queue against a queue-level reference model.
module tb_nios2_debug_slave_cmd_queue;

    localparam int DATA_W      = 38;
    localparam int IR_W        = 2;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              udr_toggle;
    logic [IR_W-1:0]   ir_in;
    logic [DATA_W-1:0] sr;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [IR_W-1:0]   cmd_ir;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] jdo;
    logic [3:0]        take_action;
    logic [3:0]        take_no_action;
    logic              ack_toggle;
    logic              overflow;
    logic [7:0]        drop_cnt;
    logic              clear_overflow;

    nios2_debug_slave_cmd_queue #(
        .DATA_W(DATA_W), .IR_W(IR_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES), .ACTION_BIT(DATA_W-1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .udr_toggle(udr_toggle), .ir_in(ir_in), .sr(sr),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .jdo(jdo), .take_action(take_action), .take_no_action(take_no_action),
        .ack_toggle(ack_toggle), .overflow(overflow), .drop_cnt(drop_cnt),
        .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                edge_no;
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] d;
    } pend_t;

    typedef struct {
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] d;
    } ent_t;

    pend_t             pend[$];
    ent_t              mq[$];
    int                edge_cnt;
    int                n_checks = 0;
    int                n_errors = 0;
    logic [DATA_W-1:0] exp_jdo;
    logic [3:0]        exp_ta;
    logic [3:0]        exp_tna;
    logic              exp_ack;
    logic              exp_ovf;
    logic [7:0]        exp_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [IR_W-1:0]   hir;
        logic [DATA_W-1:0] hd;
        hir = '0;
        hd  = '0;
        if (mq.size() > 0) begin
            hir = mq[0].ir;
            hd  = mq[0].d;
        end
        check("cmd_valid", 64'(cmd_valid), 64'(mq.size() > 0));
        check("cmd_ir", 64'(cmd_ir), 64'(hir));
        check("cmd_data", 64'(cmd_data), 64'(hd));
        check("jdo", 64'(jdo), 64'(exp_jdo));
        check("take_action", 64'(take_action), 64'(exp_ta));
        check("take_no_action", 64'(take_no_action), 64'(exp_tna));
        check("ack_toggle", 64'(ack_toggle), 64'(exp_ack));
        check("overflow", 64'(overflow), 64'(exp_ovf));
        check("drop_cnt", 64'(drop_cnt), 64'(exp_cnt));
    endtask

    task automatic model_clear();
        pend.delete();
        mq.delete();
        exp_jdo = '0;
        exp_ta  = '0;
        exp_tna = '0;
        exp_ack = 1'b0;
        exp_ovf = 1'b0;
        exp_cnt = '0;
    endtask

    // One clock edge: advance the model with the inputs the DUT samples, then compare on the falling edge.
    task automatic step();
        ent_t              e;
        bit                pop;
        bit                push;
        bit                drop;
        logic [IR_W-1:0]   pir;
        logic [DATA_W-1:0] pd;
        @(posedge clk);
        edge_cnt++;
        pop  = (mq.size() > 0) && cmd_ready;
        push = 0;
        pir  = '0;
        pd   = '0;
        while (pend.size() > 0 && pend[0].edge_no <= edge_cnt) begin
            if (pend[0].edge_no == edge_cnt && edge_cnt > SYNC_STAGES + 1) begin
                push = 1;
                pir  = pend[0].ir;
                pd   = pend[0].d;
            end
            void'(pend.pop_front());
        end
        drop = push && (mq.size() == DEPTH) && !pop;
        exp_ta  = '0;
        exp_tna = '0;
        if (pop) begin
            e       = mq.pop_front();
            exp_jdo = e.d;
            exp_ack = ~exp_ack;
            if (e.d[DATA_W-1]) exp_ta[e.ir] = 1'b1;
            else               exp_tna[e.ir] = 1'b1;
        end
        if (push && !drop) mq.push_back('{ir: pir, d: pd});
        if (clear_overflow) begin
            exp_ovf = drop;
            exp_cnt = drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            exp_ovf = 1'b1;
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
        end
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_toggle(input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] d);
        udr_toggle = ~udr_toggle;
        ir_in      = ir;
        sr         = d;
        pend.push_back('{edge_no: edge_cnt + 1 + SYNC_STAGES, ir: ir, d: d});
    endtask

    task automatic do_reset(input int ncyc, input logic tog);
        reset_n = 1'b0;
        model_clear();
        #1;
        compare_all();
        udr_toggle     = tog;
        cmd_ready      = 1'b0;
        clear_overflow = 1'b0;
        repeat (ncyc) @(negedge clk);
        reset_n  = 1'b1;
        edge_cnt = 0;
    endtask

    task automatic toggle_and_wait(input logic [IR_W-1:0] ir, input logic [DATA_W-1:0] d, input int gap);
        do_toggle(ir, d);
        repeat (gap) step();
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DATA_W-1:0];
    endfunction

    initial begin
        int gap;
        int rdy_pct;
        udr_toggle     = 1'b0;
        ir_in          = '0;
        sr             = '0;
        cmd_ready      = 1'b0;
        clear_overflow = 1'b0;
        edge_cnt       = 0;

        do_reset(3, 1'b0);
        repeat (4) step();

        cmd_ready = 1'b1;
        toggle_and_wait(2'd2, 38'h20_0000_1234, 6);
        toggle_and_wait(2'd1, 38'h00_0000_0055, 6);

        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) toggle_and_wait(IR_W'(i), {1'b1, 37'(i + 16)}, 6);
        cmd_ready = 1'b1;
        repeat (8) step();

        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        cmd_ready      = 1'b0;
        for (int i = 0; i < 4; i++) toggle_and_wait(IR_W'(3 - i), {1'b0, 37'(i + 100)}, 5);
        do_toggle(2'd3, 38'h3F_FFFF_FFFF);
        step();
        step();
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        repeat (3) step();

        do_toggle(2'd0, 38'h11_2233_4455);
        step();
        step();
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        repeat (3) step();

        for (int i = 0; i < 258; i++) toggle_and_wait(IR_W'($urandom_range(0, 3)), rand_data(), 5);
        clear_overflow = 1'b1;
        step();
        clear_overflow = 1'b0;
        cmd_ready      = 1'b1;
        repeat (6) step();

        cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) toggle_and_wait(IR_W'(i), rand_data(), 5);
        do_reset(3, udr_toggle);
        repeat (10) step();

        do_reset(3, 1'b1);
        repeat (20) step();
        cmd_ready = 1'b1;
        toggle_and_wait(2'd3, 38'h25_A5A5_A5A5, 8);

        gap     = 0;
        rdy_pct = 50;
        for (int c = 0; c < 2000; c++) begin
            if (c % 200 == 0) rdy_pct = ($urandom_range(0, 2) == 0) ? 10 : (($urandom_range(0, 1) == 0) ? 50 : 95);
            cmd_ready      = ($urandom_range(0, 99) < rdy_pct);
            clear_overflow = ($urandom_range(0, 49) == 0);
            if (gap >= 5 && $urandom_range(0, 2) == 0) begin
                do_toggle(IR_W'($urandom_range(0, 3)), rand_data());
                gap = 0;
            end
            step();
            gap++;
        end
        clear_overflow = 1'b0;
        cmd_ready      = 1'b1;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nios2_debug_slave_cmd_queue.md
# nios2_debug_slave_cmd_queue

System-clock-side command receiver for the Nios II JTAG debug slave, generalised in data width, instruction-register width and command buffering. It synchronises the update-DR toggle from the TCK-side shifter, snapshots the instruction and shifted data into a DEPTH-entry queue, and hands commands to the debug core over a valid/ready handshake. For each accepted command it raises a one-cycle per-instruction take_action or take_no_action strobe alongside a held jdo word. Overflow detection and an acknowledge toggle back to the TCK side are additions the single-register predecessor did not have.

## Interface
- DATA_W, 38: width of the shifted data word (sr, cmd_data, jdo).
- IR_W, 2: instruction width; 2**IR_W action channels.
- DEPTH, 4: queue entries; power of two, at least 2.
- SYNC_STAGES, 2: synchroniser flops on udr_toggle; at least 2.
- ACTION_BIT, DATA_W-1: bit of the data word that selects action (1) versus no-action (0).

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous assert, active-low.
- udr_toggle  in  1  from the TCK domain; inverts once per update-DR.
- ir_in  in  IR_W  TCK-domain instruction; stable ≥ SYNC_STAGES+3 clk cycles after a toggle.
- sr  in  DATA_W  TCK-domain shift register; same stability guarantee as ir_in.
- cmd_valid  out  1  queue head valid.
- cmd_ready  in  1  consumer accepts the head.
- cmd_ir  out  IR_W  head instruction.
- cmd_data  out  DATA_W  head data.
- jdo  out  DATA_W  data of the last accepted command, held.
- take_action  out  2**IR_W  one-hot strobe, one cycle.
- take_no_action  out  2**IR_W  one-hot strobe, one cycle.
- ack_toggle  out  1  inverts once per accepted command; goes to the TCK side.
- overflow  out  1  sticky; set when a command is dropped.
- drop_cnt  out  8  count of dropped commands; saturates at 255.
- clear_overflow  in  1  synchronous clear of overflow and drop_cnt.

## Operation
- **Synchroniser:** SYNC_STAGES flops on udr_toggle, plus a prev flop. capture = sync_out XOR prev.
- **Arming after reset:** a counter suppresses capture for the first SYNC_STAGES+1 cycles after reset release, while prev tracks sync_out. A toggle held at 1 through reset therefore produces no command.
- **Capture:** pushes {ir_in, sr} into the queue.
- **Queue:** circular buffer with (log2 DEPTH)+1-bit read and write pointers.
  - empty = pointers equal.
  - full = indices equal and MSBs differ.
- **Accept:** cmd_valid && cmd_ready pops the head.
- **Push while full:**
  - With a pop in the same cycle, both happen; occupancy stays DEPTH.
  - Without a pop, the command is dropped: overflow is set and drop_cnt increments, saturating.
- **Push while empty, with pop:** not possible, because cmd_valid is low. The push lands and the head becomes valid next cycle.
- **clear_overflow:** zeroes overflow and drop_cnt. If a drop happens in the same cycle, the drop wins: overflow=1, drop_cnt=1.
- **On accept, at the next edge:**
  - jdo loads cmd_data.
  - ack_toggle inverts.
  - If cmd_data[ACTION_BIT]=1, take_action[cmd_ir] pulses; otherwise take_no_action[cmd_ir] pulses.
  - All other strobe bits are 0. Strobes deassert after one cycle unless another accept occurs.
- **cmd_ready with cmd_valid low:** no effect.

## Timing
- **Reset values:** cmd_valid=0, cmd_ir=0, cmd_data=0, jdo=0, take_action=0, take_no_action=0, ack_toggle=0, overflow=0, drop_cnt=0. Pointers, synchroniser, prev and arm counter are all 0.
- **Capture latency:** a udr_toggle change first sampled at edge E is pushed at edge E+SYNC_STAGES. With an empty queue, cmd_valid is high after edge E+SYNC_STAGES; that is 3 edges for the default.
- **Accept to strobe:** 1 cycle. jdo, strobes and ack_toggle update on the same edge.
- **Throughput:** one accept per cycle. Back-to-back accepts give back-to-back strobes.
- **Combinational head:** cmd_ir and cmd_data are driven from queue storage with no extra register; they are stable while cmd_valid=1 and there is no pop.
- **Reset mid-operation:**
  - Queue contents, strobes and flags clear immediately.
  - A toggle edge in flight is lost.
  - ack_toggle returns to 0; the TCK side resynchronises on its own reset.

## Test plan
- **Single command:** reset, then toggle 0→1 with ir_in=2, sr=38'h20_0000_1234, cmd_ready=1 → cmd_valid high 3 edges later; then take_action=4'b0100 for 1 cycle, jdo=38'h20_0000_1234, ack_toggle=1.
- **No-action bit:** sr[37]=0, ir_in=1 → take_no_action=4'b0010, take_action=0.
- **Overflow:** cmd_ready=0, 5 toggles spaced 6 cycles apart → 4 entries held, overflow=1, drop_cnt=1. Then cmd_ready=1 → 4 strobes on consecutive cycles, in order, and ack_toggle ends at 0.
- **Full with pop:** queue full and cmd_ready=1 on the push cycle → no drop, overflow stays 0, occupancy stays 4.
- **Toggle high at reset release:** udr_toggle=1 during and after reset → cmd_valid stays 0 for 20 cycles; a later 1→0 toggle yields exactly one command.
- **Clear collision and mid-op reset:** clear_overflow coincident with a drop → overflow=1, drop_cnt=1. Reset asserted with 3 entries queued → all outputs 0 immediately, cmd_valid stays 0 after release.
